// File: rtl/sq_int_pkg.sv
// Shared types for the sequential integer squarer/checker.
package sq_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2
  } state_t;

endpackage

// File: rtl/sq_int_if.sv
// Operand/result bundle between a requester (master) and the squarer (slave).
interface sq_int_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] rad;
  logic             err;

  modport master (
    output start, root, rem,
    input  busy, valid, rad, err
  );

  modport slave (
    input  start, root, rem,
    output busy, valid, rad, err
  );

endinterface

// File: rtl/sq_int.sv
// Rebuilds rad = root^2 + rem with one shift-add per clock and flags pairs
// that no square-root step could have produced. WIDTH must be even and >= 4.
module sq_int
  import sq_int_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  sq_int_if.slave    bus
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_acc, w_accNext;
  logic [CW-1:0]    r_cnt, w_cntNext;
  logic [WIDTH-1:0] r_root, w_rootNext;
  logic [WIDTH-1:0] r_rem, w_remNext;
  logic [WIDTH-1:0] r_rad, w_radNext;
  logic             r_err, w_errNext;
  logic             r_busy, w_busyNext;
  logic             r_valid, w_validNext;

  logic [ITER-1:0]  w_rootLo;
  logic [CW-1:0]    w_bitIdx;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_accStep;
  logic [WIDTH-1:0] w_sum;
  logic [ITER:0]    w_twoRoot;
  logic [WIDTH-1:0] w_twoRootExt;
  logic             w_bad;

  // Root bits are consumed MSB-first; the accumulator cannot overflow for a legal root.
  assign w_rootLo     = r_root[ITER-1:0];
  assign w_bitIdx     = CW'(ITER - 1) - r_cnt;
  assign w_addend     = {{(WIDTH-ITER){1'b0}}, w_rootLo};
  assign w_accStep    = (r_acc << 1) + (w_rootLo[w_bitIdx] ? w_addend : '0);

  // Only the low WIDTH bits of the sum are kept; the carry can only be set when w_bad is.
  assign w_sum        = r_acc + r_rem;
  assign w_twoRoot    = {w_rootLo, 1'b0};
  assign w_twoRootExt = {{(WIDTH-ITER-1){1'b0}}, w_twoRoot};
  assign w_bad        = (|r_root[WIDTH-1:ITER]) || (r_rem > w_twoRootExt);

  always_comb begin
    w_stateNext = r_state;
    w_accNext   = r_acc;
    w_cntNext   = r_cnt;
    w_rootNext  = r_root;
    w_remNext   = r_rem;
    w_radNext   = r_rad;
    w_errNext   = r_err;
    w_busyNext  = r_busy;
    w_validNext = r_valid;

    // A start in any state restarts, so an abort never produces a valid pulse.
    if (bus.start) begin
      w_rootNext  = bus.root;
      w_remNext   = bus.rem;
      w_accNext   = '0;
      w_cntNext   = '0;
      w_busyNext  = 1'b1;
      w_validNext = 1'b0;
      w_stateNext = MUL;
    end else begin
      case (r_state)
        MUL: begin
          w_accNext = w_accStep;
          if (r_cnt == CW'(ITER - 1)) begin
            w_stateNext = ADD;
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
        ADD: begin
          w_errNext   = w_bad;
          w_radNext   = w_bad ? '0 : w_sum;
          w_busyNext  = 1'b0;
          w_validNext = 1'b1;
          w_stateNext = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_rad   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_acc   <= w_accNext;
      r_cnt   <= w_cntNext;
      r_root  <= w_rootNext;
      r_rem   <= w_remNext;
      r_rad   <= w_radNext;
      r_err   <= w_errNext;
      r_busy  <= w_busyNext;
      r_valid <= w_validNext;
    end
  end

  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.rad   = r_rad;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_sq_int.sv
// Bench for sq_int at WIDTH=8 and WIDTH=16 against an arithmetic model of root^2 + rem.
module tb_sq_int;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nErrors;

  sq_int_if #(.WIDTH(8))  b8 ();
  sq_int_if #(.WIDTH(16)) b16 ();

  sq_int #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  sq_int #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: illegal when the root is too wide or rem exceeds 2*root.
  function automatic void refSq(input int w, input int r, input int m,
                                output int rad, output int err);
    int lim;
    lim = 1 << (w / 2);
    err = (r >= lim || m > 2 * r) ? 1 : 0;
    rad = (err != 0) ? 0 : r * r + m;
  endfunction

  function automatic int isqrt(input int x);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    return s;
  endfunction

  // Pulses start for one cycle; returns at the negedge just after the start edge.
  task automatic applyStimulus(input bit wide, input int r, input int m);
    @(negedge clk);
    if (wide) begin
      b16.start = 1'b1;
      b16.root  = 16'(r);
      b16.rem   = 16'(m);
    end else begin
      b8.start = 1'b1;
      b8.root  = 8'(r);
      b8.rem   = 8'(m);
    end
    @(negedge clk);
    b8.start  = 1'b0;
    b16.start = 1'b0;
    b8.root   = 8'($urandom);
    b8.rem    = 8'($urandom);
    b16.root  = 16'($urandom);
    b16.rem   = 16'($urandom);
  endtask

  task automatic waitResult(input bit wide, output int rad, output int err,
                            output int cycles, output int busyCnt);
    cycles  = 0;
    busyCnt = 0;
    while (!(wide ? b16.valid : b8.valid) && cycles < 40) begin
      if (wide ? b16.busy : b8.busy) busyCnt++;
      @(negedge clk);
      cycles++;
    end
    rad = wide ? int'(b16.rad) : int'(b8.rad);
    err = wide ? int'(b16.err) : int'(b8.err);
  endtask

  task automatic runCheck(input bit wide, input int r, input int m, input string tag,
                          output int radOut, output int errOut);
    int w;
    int expRad, expErr, cycles, busyCnt;
    w = wide ? 16 : 8;
    refSq(w, r, m, expRad, expErr);
    applyStimulus(wide, r, m);
    waitResult(wide, radOut, errOut, cycles, busyCnt);
    checkOutput($sformatf("%s latency", tag), cycles, w / 2 + 1);
    checkOutput($sformatf("%s busy cycles", tag), busyCnt, w / 2 + 1);
    checkOutput($sformatf("%s rad", tag), radOut, expRad);
    checkOutput($sformatf("%s err", tag), errOut, expErr);
  endtask

  initial begin
    int rad, err, cycles, busyCnt, r, m, x;
    nChecks  = 0;
    nErrors  = 0;
    rst_n    = 1'b0;
    b8.start = 1'b0;  b8.root  = '0; b8.rem  = '0;
    b16.start = 1'b0; b16.root = '0; b16.rem = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", b8.busy, 0);
    checkOutput("reset valid", b8.valid, 0);
    checkOutput("reset rad", b8.rad, 0);
    checkOutput("reset err", b8.err, 0);
    checkOutput("reset busy16", b16.busy, 0);
    rst_n = 1'b1;

    $display("[TB] directed WIDTH=8 cases");
    runCheck(1'b0, 15, 30, "r15m30", rad, err);
    checkOutput("r15m30 const", rad, 255);
    runCheck(1'b0, 0, 0, "r0m0", rad, err);
    runCheck(1'b0, 11, 0, "r11m0", rad, err);
    checkOutput("r11m0 const", rad, 121);
    runCheck(1'b0, 5, 11, "r5m11", rad, err);
    checkOutput("r5m11 const err", err, 1);
    runCheck(1'b0, 16, 0, "r16m0", rad, err);
    checkOutput("r16m0 const err", err, 1);
    runCheck(1'b0, 15, 31, "r15m31", rad, err);

    // Restart two cycles into an operation.
    applyStimulus(1'b0, 3, 1);
    applyStimulus(1'b0, 7, 2);
    waitResult(1'b0, rad, err, cycles, busyCnt);
    checkOutput("abort latency", cycles, 5);
    checkOutput("abort rad", rad, 51);
    checkOutput("abort err", err, 0);

    // Restart landing on the ADD edge of the previous operation.
    applyStimulus(1'b0, 14, 5);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 6, 12);
    waitResult(1'b0, rad, err, cycles, busyCnt);
    checkOutput("addrestart latency", cycles, 5);
    checkOutput("addrestart rad", rad, 48);

    // Reset during MUL clears everything immediately.
    applyStimulus(1'b0, 13, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", b8.busy, 0);
    checkOutput("midreset valid", b8.valid, 0);
    checkOutput("midreset rad", b8.rad, 0);
    checkOutput("midreset err", b8.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    runCheck(1'b0, 9, 4, "r9m4", rad, err);
    checkOutput("r9m4 const", rad, 85);

    $display("[TB] random WIDTH=8 cases");
    for (int i = 0; i < 60; i++) begin
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                      : int'($urandom_range(0, 2 * (r % 16) + 2));
      runCheck(1'b0, r, m, $sformatf("rand8[%0d] r=%0d m=%0d", i, r, m), rad, err);
    end

    $display("[TB] WIDTH=16 square-root round trip");
    runCheck(1'b1, 255, 510, "r255m510", rad, err);
    checkOutput("r255m510 const", rad, 65535);
    for (int i = 0; i < 250; i++) begin
      if (i == 0) x = 0;
      else if (i == 1) x = 65535;
      else x = int'($urandom_range(0, 65535));
      r = isqrt(x);
      m = x - r * r;
      runCheck(1'b1, r, m, $sformatf("trip x=%0d", x), rad, err);
      checkOutput($sformatf("trip x=%0d roundtrip", x), rad, x);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
